// File: rtl/vpu_scratch_mem_if.sv
// Bus bundle between the host / VPU side and the scratch memory.
// The master modport drives requests; the slave modport is the memory.
interface vpu_scratch_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
);
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_go;
    logic [7:0]        host_count;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] data_c;
    logic              vpu_done;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              mem_rdy;
    logic              mem_read_en;
    logic              mem_write_en;
    logic              busy;
    logic              err;

    modport master (
        output host_we, host_addr, host_wdata, host_go, host_count,
        output addr_a, addr_b, addr_c, data_c, vpu_done,
        input  host_rdata, data_a, data_b,
        input  mem_rdy, mem_read_en, mem_write_en, busy, err
    );

    modport slave (
        input  host_we, host_addr, host_wdata, host_go, host_count,
        input  addr_a, addr_b, addr_c, data_c, vpu_done,
        output host_rdata, data_a, data_b,
        output mem_rdy, mem_read_en, mem_write_en, busy, err
    );
endinterface

// File: rtl/vpu_scratch_mem.sv
// Scratch memory shared by a host and a VPU. The host loads/reads words
// while idle; after host_go the block serves host_count VPU instructions,
// each one an ARM (mem_rdy) cycle followed by SERVE until vpu_done.
// Optional feature macro: VPU_MEM_WDOG_EN adds a 63-cycle SERVE watchdog.
module vpu_scratch_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 32
) (
    input logic              clk,
    input logic              rst_n,
    vpu_scratch_mem_if.slave bus
);
    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [7:0]        credit_reg;
    logic [DATA_W-1:0] data_a_reg;
    logic [DATA_W-1:0] data_b_reg;
    logic [DATA_W-1:0] host_rdata_reg;
    logic              mem_rdy_reg;
    logic              read_en_reg;
    logic              write_en_reg;
    logic              busy_reg;
    logic              err_reg;

    logic [DATA_W-1:0] word_arr [DEPTH];

    logic              a_ok, b_ok, c_ok, h_ok;
    logic [IDX_W-1:0]  a_idx, b_idx, c_idx, h_idx;
    logic [DATA_W-1:0] rd_a, rd_b, rd_h;
    logic              go_ok, done_serve, host_wr, vpu_wr;
    logic              serve_exit, read_upd, err_set;
    logic              wdog_expire;

    // Address range checks, read muxes (out-of-range reads as zero) and control decode
    always_comb begin
        a_ok       = bus.addr_a    < DEPTH_A;
        b_ok       = bus.addr_b    < DEPTH_A;
        c_ok       = bus.addr_c    < DEPTH_A;
        h_ok       = bus.host_addr < DEPTH_A;
        a_idx      = bus.addr_a[IDX_W-1:0];
        b_idx      = bus.addr_b[IDX_W-1:0];
        c_idx      = bus.addr_c[IDX_W-1:0];
        h_idx      = bus.host_addr[IDX_W-1:0];
        rd_a       = a_ok ? word_arr[a_idx] : '0;
        rd_b       = b_ok ? word_arr[b_idx] : '0;
        rd_h       = h_ok ? word_arr[h_idx] : '0;
        go_ok      = (state_reg == IDLE) && bus.host_go && (bus.host_count != 8'd0);
        done_serve = (state_reg == SERVE) && bus.vpu_done;
        host_wr    = (state_reg == IDLE) && bus.host_we && h_ok;
        vpu_wr     = done_serve && c_ok;
        serve_exit = (done_serve && (credit_reg == 8'd1)) || wdog_expire;
        // Operand reads refresh only on edges that leave the block in ARM/SERVE,
        // so data_a/data_b hold their last value while mem_read_en is low.
        read_upd   = go_ok || (state_reg == ARM) || ((state_reg == SERVE) && !serve_exit);
        err_set    = (bus.host_we  && ((state_reg != IDLE)  || !h_ok))
                   || (bus.vpu_done && ((state_reg != SERVE) || !c_ok))
                   || wdog_expire;
    end

    // Storage words; host and VPU writes are exclusive because they need different states
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [DATA_W-1:0] word_reg;

        // One word: cleared by reset, written by the VPU in SERVE or the host in IDLE
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_reg <= '0;
            end else if (vpu_wr && (c_idx == IDX_W'(gi))) begin
                word_reg <= bus.data_c;
            end else if (host_wr && (h_idx == IDX_W'(gi))) begin
                word_reg <= bus.host_wdata;
            end
        end

        assign word_arr[gi] = word_reg;
    end

`ifdef VPU_MEM_WDOG_EN
    logic [5:0] wdog_reg;

    // Watchdog: restarts in ARM (entry to SERVE), counts every SERVE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_reg <= '0;
        end else if (state_reg == ARM) begin
            wdog_reg <= '0;
        end else if (state_reg == SERVE) begin
            wdog_reg <= wdog_reg + 6'd1;
        end
    end

    // The 63rd SERVE cycle without vpu_done is the last one
    assign wdog_expire = (state_reg == SERVE) && !bus.vpu_done && (wdog_reg == 6'd62);
`else
    assign wdog_expire = 1'b0;
`endif

    // Control FSM with registered handshake outputs, read ports and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            credit_reg     <= '0;
            mem_rdy_reg    <= 1'b0;
            read_en_reg    <= 1'b0;
            write_en_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
            data_a_reg     <= '0;
            data_b_reg     <= '0;
            host_rdata_reg <= '0;
        end else begin
            write_en_reg   <= done_serve;
            host_rdata_reg <= rd_h;
            if (read_upd) begin
                data_a_reg <= rd_a;
                data_b_reg <= rd_b;
            end
            // A new error in the same cycle as an accepted go wins over the clear
            if (err_set) begin
                err_reg <= 1'b1;
            end else if (go_ok) begin
                err_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (go_ok) begin
                        credit_reg  <= bus.host_count;
                        state_reg   <= ARM;
                        mem_rdy_reg <= 1'b1;
                        read_en_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                    end
                end
                ARM: begin
                    state_reg   <= SERVE;
                    mem_rdy_reg <= 1'b0;
                end
                SERVE: begin
                    if (done_serve) begin
                        credit_reg <= credit_reg - 8'd1;
                        if (credit_reg != 8'd1) begin
                            state_reg   <= ARM;
                            mem_rdy_reg <= 1'b1;
                        end else begin
                            state_reg   <= IDLE;
                            read_en_reg <= 1'b0;
                            busy_reg    <= 1'b0;
                        end
                    end else if (wdog_expire) begin
                        state_reg   <= IDLE;
                        credit_reg  <= '0;
                        read_en_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    credit_reg  <= '0;
                    mem_rdy_reg <= 1'b0;
                    read_en_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_a       = data_a_reg;
    assign bus.data_b       = data_b_reg;
    assign bus.host_rdata   = host_rdata_reg;
    assign bus.mem_rdy      = mem_rdy_reg;
    assign bus.mem_read_en  = read_en_reg;
    assign bus.mem_write_en = write_en_reg;
    assign bus.busy         = busy_reg;
    assign bus.err          = err_reg;
endmodule

// File: tb/tb_vpu_scratch_mem.sv
// Testbench for vpu_scratch_mem: directed scenarios plus random traffic.
// A reference model steps on each rising edge and queues the expected
// outputs; a monitor pops and compares them on the following falling edge.
module tb_vpu_scratch_mem;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    vpu_scratch_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vpu_scratch_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] da;
        logic [DATA_W-1:0] db;
        logic [DATA_W-1:0] hr;
        logic              rdy;
        logic              ren;
        logic              wen;
        logic              busy;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int rdy_seen = 0;

    // Reference model state: phase 0 = idle, 1 = arm, 2 = serve
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                ref_phase;
    int                ref_credit;
    int                ref_wd;
    logic [DATA_W-1:0] ref_da, ref_db;
    logic              ref_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        if (int'(a) < DEPTH) return ref_mem[int'(a)];
        return '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_phase  = 0;
        ref_credit = 0;
        ref_wd     = 0;
        ref_da     = '0;
        ref_db     = '0;
        ref_err    = 1'b0;
        exp_q.delete();
    endtask

    // One clock of the specified behaviour, applied to the sampled inputs
    task automatic model_step();
        exp_t              e;
        logic [DATA_W-1:0] ra, rb, rh;
        bit                eset, eclr;
        ra    = ref_rd(bus.addr_a);
        rb    = ref_rd(bus.addr_b);
        rh    = ref_rd(bus.host_addr);
        eset  = 0;
        eclr  = 0;
        e.wen = 1'b0;
        if (ref_phase == 0) begin
            if (bus.host_we) begin
                if (int'(bus.host_addr) < DEPTH) ref_mem[int'(bus.host_addr)] = bus.host_wdata;
                else eset = 1;
            end
            if (bus.vpu_done) eset = 1;
            if (bus.host_go && bus.host_count != 0) begin
                ref_credit = int'(bus.host_count);
                ref_phase  = 1;
                eclr       = 1;
            end
        end else if (ref_phase == 1) begin
            if (bus.host_we)  eset = 1;
            if (bus.vpu_done) eset = 1;
            ref_phase = 2;
            ref_wd    = 0;
        end else begin
            if (bus.host_we) eset = 1;
            if (bus.vpu_done) begin
                e.wen = 1'b1;
                if (int'(bus.addr_c) < DEPTH) ref_mem[int'(bus.addr_c)] = bus.data_c;
                else eset = 1;
                ref_credit--;
                ref_phase = (ref_credit != 0) ? 1 : 0;
            end else begin
                ref_wd++;
`ifdef VPU_MEM_WDOG_EN
                if (ref_wd == 63) begin
                    ref_phase  = 0;
                    ref_credit = 0;
                    eset       = 1;
                end
`endif
            end
        end
        if (eclr) ref_err = 1'b0;
        if (eset) ref_err = 1'b1;
        if (ref_phase != 0) begin
            ref_da = ra;
            ref_db = rb;
        end
        e.da   = ref_da;
        e.db   = ref_db;
        e.hr   = rh;
        e.rdy  = (ref_phase == 1);
        e.ren  = (ref_phase != 0);
        e.busy = (ref_phase != 0);
        e.err  = ref_err;
        exp_q.push_back(e);
    endtask

    // Model: evaluates on every rising edge while out of reset
    initial forever begin
        @(posedge clk);
        if (rst_n) model_step();
    end

    // Monitor: compares DUT outputs against the oldest queued expectation
    initial forever begin
        @(negedge clk);
        if (bus.mem_rdy === 1'b1) rdy_seen++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("data_a",       bus.data_a,       mon_e.da);
            chk("data_b",       bus.data_b,       mon_e.db);
            chk("host_rdata",   bus.host_rdata,   mon_e.hr);
            chk("mem_rdy",      bus.mem_rdy,      mon_e.rdy);
            chk("mem_read_en",  bus.mem_read_en,  mon_e.ren);
            chk("mem_write_en", bus.mem_write_en, mon_e.wen);
            chk("busy",         bus.busy,         mon_e.busy);
            chk("err",          bus.err,          mon_e.err);
        end
    end

    // Stimulus tasks: called at a falling edge, drive, and return at the next one
    task automatic idle_tick();
        bus.host_we  = 1'b0;
        bus.host_go  = 1'b0;
        bus.vpu_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic host_write(input int a, input logic [DATA_W-1:0] d);
        $display("[%0t] host_write addr=%0d data=%0h", $time, a, d);
        bus.host_we    = 1'b1;
        bus.host_addr  = ADDR_W'(a);
        bus.host_wdata = d;
        @(negedge clk);
        bus.host_we    = 1'b0;
    endtask

    task automatic host_read(input int a);
        $display("[%0t] host_read addr=%0d", $time, a);
        bus.host_addr = ADDR_W'(a);
        @(negedge clk);
    endtask

    task automatic go(input int cnt);
        $display("[%0t] host_go count=%0d", $time, cnt);
        bus.host_go    = 1'b1;
        bus.host_count = 8'(cnt);
        @(negedge clk);
        bus.host_go    = 1'b0;
    endtask

    task automatic vpu_op(input int a, input int b, input int c, input logic [DATA_W-1:0] d);
        $display("[%0t] vpu_done a=%0d b=%0d c=%0d data_c=%0h", $time, a, b, c, d);
        bus.addr_a   = ADDR_W'(a);
        bus.addr_b   = ADDR_W'(b);
        bus.addr_c   = ADDR_W'(c);
        bus.data_c   = d;
        bus.vpu_done = 1'b1;
        @(negedge clk);
        bus.vpu_done = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while (ref_phase != p && n < 100) begin
            idle_tick();
            n++;
        end
        if (ref_phase != p) begin
            checks++;
            errors++;
            $display("FAIL wait_phase: actual=%0d required=%0d (timeout)", ref_phase, p);
        end
    endtask

    task automatic reset_pulse();
        $display("[%0t] reset pulse", $time);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_data_a",   bus.data_a,       0);
        chk("rst_data_b",   bus.data_b,       0);
        chk("rst_rdata",    bus.host_rdata,   0);
        chk("rst_mem_rdy",  bus.mem_rdy,      0);
        chk("rst_read_en",  bus.mem_read_en,  0);
        chk("rst_write_en", bus.mem_write_en, 0);
        chk("rst_busy",     bus.busy,         0);
        chk("rst_err",      bus.err,          0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        bus.host_go    = 1'b0;
        bus.host_count = '0;
        bus.addr_a     = '0;
        bus.addr_b     = '0;
        bus.addr_c     = '0;
        bus.data_c     = '0;
        bus.vpu_done   = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("init_busy",    bus.busy,        0);
        chk("init_err",     bus.err,         0);
        chk("init_read_en", bus.mem_read_en, 0);
        chk("init_data_a",  bus.data_a,      0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic load / serve / read-back
        host_write(3, 5);
        host_write(4, 7);
        bus.addr_a = 3;
        bus.addr_b = 4;
        go(1);
        chk("r030_mem_rdy", bus.mem_rdy, 1);
        chk("r030_data_a",  bus.data_a,  5);
        chk("r030_data_b",  bus.data_b,  7);
        wait_phase(2);
        vpu_op(3, 4, 6, 12);
        chk("r030_write_en", bus.mem_write_en, 1);
        wait_phase(0);
        host_read(6);
        chk("r030_rdata", bus.host_rdata, 12);
        chk("r030_busy",  bus.busy,       0);

        // Three credits, then a stray completion
        r0 = rdy_seen;
        go(3);
        for (int i = 0; i < 3; i++) begin
            wait_phase(2);
            vpu_op($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
        end
        wait_phase(0);
        idle_tick();
        chk("r031_rdy_pulses", rdy_seen - r0, 3);
        vpu_op(1, 2, 9, 32'h1234);
        chk("r031_err", bus.err, 1);

        // Out-of-range operand and result
        bus.addr_a = 40;
        go(1);
        wait_phase(2);
        vpu_op(40, 3, 40, 32'hdead);
        chk("r032_data_a", bus.data_a, 0);
        chk("r032_err",    bus.err,    1);
        idle_tick();

        // Host write while serving, then err clear on next go
        go(1);
        wait_phase(2);
        host_write(5, 32'hbad);
        chk("r033_err", bus.err, 1);
        vpu_op(5, 5, 7, 32'h77);
        wait_phase(0);
        host_read(5);
        chk("r033_rdata", bus.host_rdata, 0);
        go(1);
        chk("r033_err_clr", bus.err, 0);
        wait_phase(2);
        vpu_op(7, 6, 8, 32'h88);
        wait_phase(0);

        // Reset in the middle of SERVE
        host_write(6, 32'h66);
        go(1);
        wait_phase(2);
        reset_pulse();
        vpu_op(1, 2, 6, 32'h99);
        host_read(6);
        chk("r034_rdata", bus.host_rdata, 0);
        chk("r034_err",   bus.err,        1);

`ifdef VPU_MEM_WDOG_EN
        // Watchdog expiry with no completion
        go(1);
        repeat (70) idle_tick();
        chk("wdog_busy", bus.busy, 0);
        chk("wdog_err",  bus.err,  1);
`endif

        // Random traffic
        for (int i = 0; i < 250; i++) begin
            int op;
            op = $urandom_range(0, 5);
            bus.addr_a = ADDR_W'($urandom_range(0, 39));
            bus.addr_b = ADDR_W'($urandom_range(0, 39));
            case (op)
                0:       host_write($urandom_range(0, 39), $urandom);
                1:       host_read($urandom_range(0, 39));
                2:       go($urandom_range(0, 4));
                3, 4:    vpu_op($urandom_range(0, 39), $urandom_range(0, 39),
                                $urandom_range(0, 39), $urandom);
                default: idle_tick();
            endcase
        end

        // Drain any outstanding credits
        for (int i = 0; i < 300 && ref_phase != 0; i++) begin
            if (ref_phase == 2) vpu_op($urandom_range(0, 31), $urandom_range(0, 31),
                                       $urandom_range(0, 31), $urandom);
            else idle_tick();
        end
        wait_phase(0);
        idle_tick();
        idle_tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
